// File: rtl/huffman_bit_packer.sv
// Packs right-aligned variable-length codewords MSB-first into bytes at 1 bit/clk; one output register with stall on full.
// Optional PACKER_BITCOUNT_EN adds a free-running total_bits count of codeword bits shifted.
module huffman_bit_packer #(
  parameter int MAX_CODE_LEN = 16,
  parameter int LEN_W        = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    code_valid,
  output logic                    code_ready,
  input  logic [MAX_CODE_LEN-1:0] code_bits,
  input  logic [LEN_W-1:0]        code_len,
  input  logic                    flush,
  output logic                    flush_done,
  output logic                    byte_valid,
  input  logic                    byte_ready,
  output logic [7:0]              byte_data,
  output logic                    bit_strobe
`ifdef PACKER_BITCOUNT_EN
  ,
  output logic [31:0]             total_bits
`endif
);

  typedef enum logic [1:0] {IDLE, SHIFT, PAD} state_t;

  state_t                  state_q, state_d;
  logic [MAX_CODE_LEN-1:0] word_q, word_d;
  logic [LEN_W-1:0]        cnt_q, cnt_d;
  logic [7:0]              acc_q, acc_d;
  logic [2:0]              bit_pos_q, bit_pos_d;
  logic [7:0]              out_q, out_d;
  logic                    out_vld_q, out_vld_d;

  logic [LEN_W-1:0]        len_clamped;
  logic                    out_free;
  logic                    load;
  logic [7:0]              load_byte;
  logic [7:0]              acc_bit;

  always_comb begin
    len_clamped = (code_len > LEN_W'(MAX_CODE_LEN)) ? LEN_W'(MAX_CODE_LEN) : code_len;
    // The output register can take a new byte if empty or draining this cycle.
    out_free    = !out_vld_q || byte_ready;
    acc_bit     = acc_q;
    acc_bit[~bit_pos_q] = word_q[MAX_CODE_LEN-1];

    state_d    = state_q;
    word_d     = word_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    bit_pos_d  = bit_pos_q;
    code_ready = 1'b0;
    bit_strobe = 1'b0;
    flush_done = 1'b0;
    load       = 1'b0;
    load_byte  = acc_q;

    case (state_q)
      IDLE: begin
        code_ready = 1'b1;
        if (code_valid) begin
          if (len_clamped != '0) begin
            // Left-align so the next bit to send is always the MSB.
            word_d  = code_bits << (LEN_W'(MAX_CODE_LEN) - len_clamped);
            cnt_d   = len_clamped;
            state_d = SHIFT;
          end
        end else if (flush) begin
          state_d = PAD;
        end
      end
      SHIFT: begin
        if (bit_pos_q != 3'd7 || out_free) begin
          bit_strobe = 1'b1;
          word_d     = word_q << 1;
          cnt_d      = cnt_q - LEN_W'(1);
          bit_pos_d  = bit_pos_q + 3'd1;
          if (bit_pos_q == 3'd7) begin
            load      = 1'b1;
            load_byte = acc_bit;
            acc_d     = '0;
          end else begin
            acc_d = acc_bit;
          end
          if (cnt_q == LEN_W'(1)) begin
            state_d = IDLE;
          end
        end
      end
      PAD: begin
        if (bit_pos_q == 3'd0) begin
          flush_done = 1'b1;
          state_d    = IDLE;
        end else if (out_free) begin
          // Unwritten positions of the accumulator are already zero.
          flush_done = 1'b1;
          load       = 1'b1;
          load_byte  = acc_q;
          acc_d      = '0;
          bit_pos_d  = 3'd0;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    out_vld_d = out_vld_q && !byte_ready;
    out_d     = out_q;
    if (load) begin
      out_vld_d = 1'b1;
      out_d     = load_byte;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      word_q    <= '0;
      cnt_q     <= '0;
      acc_q     <= '0;
      bit_pos_q <= '0;
      out_q     <= '0;
      out_vld_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      word_q    <= word_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      bit_pos_q <= bit_pos_d;
      out_q     <= out_d;
      out_vld_q <= out_vld_d;
    end
  end

  assign byte_valid = out_vld_q;
  assign byte_data  = out_q;

`ifdef PACKER_BITCOUNT_EN
  logic [31:0] total_bits_q, total_bits_d;

  always_comb begin
    total_bits_d = total_bits_q + (bit_strobe ? 32'd1 : 32'd0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      total_bits_q <= '0;
    end else begin
      total_bits_q <= total_bits_d;
    end
  end

  assign total_bits = total_bits_q;
`endif

endmodule

// File: tb/tb_huffman_bit_packer.sv
// Directed bench for huffman_bit_packer: byte packing, flush, backpressure, reset and clamping.
module tb_huffman_bit_packer;

  logic        clk = 1'b0;
  logic        rst;
  logic        code_valid;
  logic        code_ready;
  logic [15:0] code_bits;
  logic [4:0]  code_len;
  logic        flush;
  logic        flush_done;
  logic        byte_valid;
  logic        byte_ready;
  logic [7:0]  byte_data;
  logic        bit_strobe;
`ifdef PACKER_BITCOUNT_EN
  logic [31:0] total_bits;
`endif

  int tests = 0;
  int fails = 0;

  logic [7:0] got[$];
  int strobe_cnt = 0;
  int fd_cnt     = 0;
  int rdy_low    = 0;

  huffman_bit_packer #(.MAX_CODE_LEN(16), .LEN_W(5)) dut (
    .clk        (clk),
    .rst        (rst),
    .code_valid (code_valid),
    .code_ready (code_ready),
    .code_bits  (code_bits),
    .code_len   (code_len),
    .flush      (flush),
    .flush_done (flush_done),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .byte_data  (byte_data),
    .bit_strobe (bit_strobe)
`ifdef PACKER_BITCOUNT_EN
    ,
    .total_bits (total_bits)
`endif
  );

  always #5 clk = ~clk;

  // Observe the cycle's values mid-period; handshakes complete at the following rising edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (byte_valid && byte_ready) got.push_back(byte_data);
      if (bit_strobe) strobe_cnt++;
      if (flush_done) fd_cnt++;
      if (!code_ready) rdy_low++;
    end
  end

  function automatic logic [7:0] qget(input int idx);
    if (idx < got.size()) return got[idx];
    return 8'hxx;
  endfunction

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] b, input logic [4:0] l);
    int n;
    n = 0;
    code_bits  = b;
    code_len   = l;
    code_valid = 1'b1;
    @(negedge clk);
    while (!code_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (n >= 200) begin
      fails++;
      $display("FAIL send_accept: code_ready=%0b after %0d cycles, required 1", code_ready, n);
    end
    @(posedge clk);
    #1;
    code_valid = 1'b0;
  endtask

  task automatic do_flush();
    int n;
    n = 0;
    flush = 1'b1;
    @(negedge clk);
    while (!flush_done && n < 50) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (n >= 50) begin
      fails++;
      $display("FAIL flush_timeout: flush_done=%0b after %0d cycles, required 1", flush_done, n);
    end
    @(posedge clk);
    #1;
    flush = 1'b0;
  endtask

  task automatic test_reset();
    rst        = 1'b1;
    code_valid = 1'b0;
    code_bits  = '0;
    code_len   = '0;
    flush      = 1'b0;
    byte_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    tests++;
    if (code_ready !== 1'b1) begin fails++; $display("FAIL reset_code_ready: got %0b, required 1", code_ready); end
    tests++;
    if (byte_valid !== 1'b0) begin fails++; $display("FAIL reset_byte_valid: got %0b, required 0", byte_valid); end
    tests++;
    if (byte_data !== 8'h00) begin fails++; $display("FAIL reset_byte_data: got %h, required 00", byte_data); end
    tests++;
    if (bit_strobe !== 1'b0 || flush_done !== 1'b0) begin
      fails++;
      $display("FAIL reset_pulses: strobe=%0b flush_done=%0b, required 0 0", bit_strobe, flush_done);
    end
  endtask

  task automatic test_basic_pack();
    int sb, qb, rb;
    sb = strobe_cnt; qb = got.size(); rb = rdy_low;
    byte_ready = 1'b1;
    send(16'h0005, 5'd3);
    send(16'h0013, 5'd5);
    idle(12);
    tests++;
    if (got.size() - qb !== 1) begin fails++; $display("FAIL basic_byte_count: got %0d, required 1", got.size() - qb); end
    tests++;
    if (qget(qb) !== 8'hB3) begin fails++; $display("FAIL basic_byte_value: got %h, required b3", qget(qb)); end
    tests++;
    if (strobe_cnt - sb !== 8) begin fails++; $display("FAIL basic_strobes: got %0d, required 8", strobe_cnt - sb); end
    tests++;
    if (rdy_low - rb !== 8) begin fails++; $display("FAIL basic_ready_low: got %0d, required 8", rdy_low - rb); end
  endtask

  task automatic test_flush();
    int qb, fb;
    qb = got.size(); fb = fd_cnt;
    send(16'h0003, 5'd2);
    idle(4);
    do_flush();
    idle(3);
    tests++;
    if (got.size() - qb !== 1 || qget(qb) !== 8'hC0) begin
      fails++;
      $display("FAIL flush_pad_byte: count %0d value %h, required 1 c0", got.size() - qb, qget(qb));
    end
    tests++;
    if (fd_cnt - fb !== 1) begin fails++; $display("FAIL flush_done_once: got %0d, required 1", fd_cnt - fb); end
    do_flush();
    idle(3);
    tests++;
    if (got.size() - qb !== 1) begin fails++; $display("FAIL flush_empty_no_byte: got %0d bytes, required 1", got.size() - qb); end
    tests++;
    if (fd_cnt - fb !== 2) begin fails++; $display("FAIL flush_empty_done: got %0d, required 2", fd_cnt - fb); end
  endtask

  task automatic test_back_to_back();
    int sb, qb;
    sb = strobe_cnt; qb = got.size();
    byte_ready = 1'b0;
    send(16'hA5C3, 5'd16);
    idle(30);
    tests++;
    if (byte_valid !== 1'b1 || byte_data !== 8'hA5) begin
      fails++;
      $display("FAIL bp_held: valid=%0b data=%h, required 1 a5", byte_valid, byte_data);
    end
    tests++;
    if (strobe_cnt - sb !== 15) begin fails++; $display("FAIL bp_stall_strobes: got %0d, required 15", strobe_cnt - sb); end
    tests++;
    if (code_ready !== 1'b0) begin fails++; $display("FAIL bp_code_ready: got %0b, required 0", code_ready); end
    idle(5);
    tests++;
    if (byte_data !== 8'hA5 || strobe_cnt - sb !== 15) begin
      fails++;
      $display("FAIL bp_stable: data=%h strobes=%0d, required a5 15", byte_data, strobe_cnt - sb);
    end
    byte_ready = 1'b1;
    idle(6);
    tests++;
    if (got.size() - qb !== 2 || qget(qb) !== 8'hA5 || qget(qb + 1) !== 8'hC3) begin
      fails++;
      $display("FAIL bp_drain: count %0d bytes %h %h, required 2 a5 c3", got.size() - qb, qget(qb), qget(qb + 1));
    end
    tests++;
    if (strobe_cnt - sb !== 16) begin fails++; $display("FAIL bp_total_strobes: got %0d, required 16", strobe_cnt - sb); end
  endtask

  task automatic test_zero_len_and_priority();
    int sb, qb, rb, fb, n, s_at_done;
    sb = strobe_cnt; qb = got.size(); rb = rdy_low;
    byte_ready = 1'b1;
    send(16'h0000, 5'd0);
    idle(4);
    tests++;
    if (strobe_cnt - sb !== 0 || got.size() - qb !== 0 || rdy_low - rb !== 0) begin
      fails++;
      $display("FAIL zero_len: strobes %0d bytes %0d ready_low %0d, required 0 0 0",
               strobe_cnt - sb, got.size() - qb, rdy_low - rb);
    end
    sb = strobe_cnt; fb = fd_cnt;
    code_bits = 16'h0007; code_len = 5'd3; code_valid = 1'b1; flush = 1'b1;
    @(negedge clk);
    tests++;
    if (code_ready !== 1'b1) begin fails++; $display("FAIL prio_accept: code_ready=%0b, required 1", code_ready); end
    @(posedge clk);
    #1;
    code_valid = 1'b0;
    n = 0;
    @(negedge clk);
    while (!flush_done && n < 50) begin
      @(negedge clk);
      n++;
    end
    s_at_done = strobe_cnt - sb;
    @(posedge clk);
    #1;
    flush = 1'b0;
    idle(3);
    tests++;
    if (s_at_done !== 3) begin fails++; $display("FAIL prio_order: strobes before flush_done %0d, required 3", s_at_done); end
    tests++;
    if (got.size() - qb !== 1 || qget(qb) !== 8'hE0 || fd_cnt - fb !== 1) begin
      fails++;
      $display("FAIL prio_pad: count %0d byte %h done %0d, required 1 e0 1", got.size() - qb, qget(qb), fd_cnt - fb);
    end
  endtask

  task automatic test_reset_mid();
    int qb;
    qb = got.size();
    byte_ready = 1'b1;
    send(16'h0055, 5'd8);
    repeat (5) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    tests++;
    if (byte_valid !== 1'b0 || byte_data !== 8'h00 || bit_strobe !== 1'b0 || flush_done !== 1'b0) begin
      fails++;
      $display("FAIL rst_mid_outputs: valid=%0b data=%h strobe=%0b done=%0b, required 0 00 0 0",
               byte_valid, byte_data, bit_strobe, flush_done);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    send(16'h00FF, 5'd8);
    idle(12);
    tests++;
    if (got.size() - qb !== 1 || qget(qb) !== 8'hFF) begin
      fails++;
      $display("FAIL rst_mid_clean: count %0d byte %h, required 1 ff", got.size() - qb, qget(qb));
    end
  endtask

  task automatic test_clamp();
    int sb, qb;
    sb = strobe_cnt; qb = got.size();
    send(16'h1234, 5'd31);
    idle(20);
    tests++;
    if (got.size() - qb !== 2 || qget(qb) !== 8'h12 || qget(qb + 1) !== 8'h34) begin
      fails++;
      $display("FAIL clamp_bytes: count %0d bytes %h %h, required 2 12 34", got.size() - qb, qget(qb), qget(qb + 1));
    end
    tests++;
    if (strobe_cnt - sb !== 16) begin fails++; $display("FAIL clamp_strobes: got %0d, required 16", strobe_cnt - sb); end
  endtask

`ifdef PACKER_BITCOUNT_EN
  task automatic test_bitcount();
    rst = 1'b1;
    #3;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    send(16'h0005, 5'd3);
    send(16'h0013, 5'd5);
    send(16'h001F, 5'd5);
    idle(8);
    do_flush();
    idle(3);
    tests++;
    if (total_bits !== 32'd13) begin fails++; $display("FAIL bitcount_13: got %0d, required 13", total_bits); end
    force dut.total_bits_q = 32'hFFFF_FFFE;
    #1;
    release dut.total_bits_q;
    idle(1);
    send(16'h0007, 5'd3);
    idle(6);
    tests++;
    if (total_bits !== 32'd1) begin fails++; $display("FAIL bitcount_wrap: got %h, required 00000001", total_bits); end
  endtask
`endif

  initial begin
    test_reset();
    test_basic_pack();
    test_flush();
    test_back_to_back();
    test_zero_len_and_priority();
    test_reset_mid();
    test_clamp();
`ifdef PACKER_BITCOUNT_EN
    test_bitcount();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, required to finish", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
